// File: rtl/idma_axis_read_sched.sv
// idma_axis_read_sched: shares one AXIS r_dp read datapath between channels.
// Round-robin owner is locked until its last beat and all responses drain.
module idma_axis_read_sched #(
    parameter int unsigned NumChan  = 4,
    parameter int unsigned ReqWidth = 32,
    parameter int unsigned RspWidth = 4,
    parameter int unsigned MaxOutst = 2,
    parameter int unsigned CntWidth = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NumChan*ReqWidth-1:0]  ch_req_i,
    input  logic [NumChan-1:0]           ch_last_i,
    input  logic [NumChan-1:0]           ch_valid_i,
    output logic [NumChan-1:0]           ch_ready_o,
    output logic [RspWidth-1:0]          ch_rsp_o,
    output logic [NumChan-1:0]           ch_rsp_valid_o,
    input  logic [NumChan-1:0]           ch_rsp_ready_i,
    output logic [ReqWidth-1:0]          dp_req_o,
    output logic                         dp_req_valid_o,
    input  logic                         dp_req_ready_i,
    input  logic [RspWidth-1:0]          dp_rsp_i,
    input  logic                         dp_rsp_valid_i,
    output logic                         dp_rsp_ready_o,
    output logic                         busy_o,
    output logic [$clog2(NumChan)-1:0]   owner_o,
    output logic [CntWidth-1:0]          beats_o
);

    localparam int unsigned OwW = $clog2(NumChan);
    localparam int unsigned OsW = $clog2(MaxOutst + 1);
    localparam logic [OsW-1:0] OsMax = OsW'(MaxOutst);
    localparam logic [OwW:0] NumChanW = (OwW+1)'(NumChan);
    localparam logic [OwW-1:0] LastCh = OwW'(NumChan - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e              state;
    logic [OwW-1:0]      rr_ptr;
    logic [OwW-1:0]      owner;
    logic [OsW-1:0]      outst;
    logic [OsW-1:0]      outst_nxt;
    logic                done_req;
    logic [CntWidth-1:0] beats;
    logic [OwW-1:0]      pick;
    logic                pick_vld;
    logic [OwW:0]        idx;
    logic                gate;
    logic                rsp_ok;
    logic                req_hs;
    logic                rsp_hs;

    // First valid channel at or after rr_ptr, wrapping around.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int i = 0; i < int'(NumChan); i++) begin
            idx = {1'b0, rr_ptr} + (OwW+1)'(i);
            if (idx >= NumChanW) idx = idx - NumChanW;
            if (!pick_vld && ch_valid_i[idx[OwW-1:0]]) begin
                pick_vld = 1'b1;
                pick     = idx[OwW-1:0];
            end
        end
    end

    // Owner routing of request and response paths with outstanding gating.
    always_comb begin
        gate = !rst_i && (state == BUSY) && ch_valid_i[owner]
               && !done_req && (outst != OsMax);
        rsp_ok = !rst_i && (state == BUSY) && (outst != '0);

        dp_req_o       = ch_req_i[int'(owner)*ReqWidth +: ReqWidth];
        dp_req_valid_o = gate;
        ch_ready_o     = '0;
        if (gate) ch_ready_o[owner] = dp_req_ready_i;
        req_hs = gate && dp_req_ready_i;

        ch_rsp_o       = dp_rsp_i;
        ch_rsp_valid_o = '0;
        if (rsp_ok) ch_rsp_valid_o[owner] = dp_rsp_valid_i;
        dp_rsp_ready_o = rsp_ok && ch_rsp_ready_i[owner];
        rsp_hs = dp_rsp_ready_o && dp_rsp_valid_i;

        unique case ({req_hs, rsp_hs})
            2'b10:   outst_nxt = outst + OsW'(1);
            2'b01:   outst_nxt = outst - OsW'(1);
            default: outst_nxt = outst;
        endcase
    end

    // Grant FSM: arbitrate in IDLE, count beats in BUSY, release on drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            outst    <= '0;
            beats    <= '0;
            done_req <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner  <= pick;
                        beats  <= '0;
                        state  <= BUSY;
                        busy_o <= 1'b1;
                    end
                end
                BUSY: begin
                    outst <= outst_nxt;
                    if (req_hs) begin
                        if (beats != '1) beats <= beats + CntWidth'(1);
                        if (ch_last_i[owner]) done_req <= 1'b1;
                    end
                    if (done_req && outst_nxt == '0) begin
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        done_req <= 1'b0;
                        outst    <= '0;
                        rr_ptr   <= (owner == LastCh) ? '0 : owner + OwW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign owner_o = owner;
    assign beats_o = beats;

    // A response with nothing outstanding means the datapath lost track.
    a_no_stray_rsp : assert property (@(posedge clk_i) disable iff (rst_i)
        !(dp_rsp_valid_i && (state == IDLE || outst == '0)));

endmodule

// File: tb/tb_idma_axis_read_sched.sv
// tb_idma_axis_read_sched: random and directed traffic against a
// transaction-level model of the round-robin owner-lock scheduler.
module tb_idma_axis_read_sched;

    localparam int N  = 4;
    localparam int RW = 32;
    localparam int SW = 4;
    localparam int MO = 2;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*RW-1:0] ch_req;
    logic [N-1:0]    ch_last, ch_valid, ch_ready;
    logic [SW-1:0]   ch_rsp;
    logic [N-1:0]    ch_rsp_valid, ch_rsp_ready;
    logic [RW-1:0]   dp_req;
    logic            dp_req_valid, dp_req_ready;
    logic [SW-1:0]   dp_rsp;
    logic            dp_rsp_valid, dp_rsp_ready;
    logic            busy;
    logic [1:0]      owner;
    logic [CW-1:0]   beats;

    idma_axis_read_sched #(
        .NumChan(N), .ReqWidth(RW), .RspWidth(SW),
        .MaxOutst(MO), .CntWidth(CW)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ch_req_i(ch_req), .ch_last_i(ch_last),
        .ch_valid_i(ch_valid), .ch_ready_o(ch_ready),
        .ch_rsp_o(ch_rsp), .ch_rsp_valid_o(ch_rsp_valid),
        .ch_rsp_ready_i(ch_rsp_ready),
        .dp_req_o(dp_req), .dp_req_valid_o(dp_req_valid),
        .dp_req_ready_i(dp_req_ready),
        .dp_rsp_i(dp_rsp), .dp_rsp_valid_i(dp_rsp_valid),
        .dp_rsp_ready_o(dp_rsp_ready),
        .busy_o(busy), .owner_o(owner), .beats_o(beats)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Model: grant holder, round-robin pointer, outstanding beats.
    bit            m_busy, m_done;
    int            m_owner, m_rr, m_outst, m_beats;
    int            grants[$];
    logic [SW-1:0] rspq[$];

    // Channel drivers and stimulus knobs.
    bit [N-1:0]    act;
    int            rem[N];
    logic [RW-1:0] cur_req[N];
    int            sent[N], recvd[N];
    int            start_pct, rdy_pct, rsp_pct, crr_pct;
    bit            bub, rsp_hold;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(int c, int len);
        act[c]     = 1'b1;
        rem[c]     = len;
        cur_req[c] = $urandom;
    endtask

    function automatic bit all_idle();
        return (act == '0) && !m_busy;
    endfunction

    task automatic cycle();
        bit            ev, eo, req_hs, rsp_hs, lst, found;
        logic [N-1:0]  er, ecv;
        // registered status from the previous edge
        chk("busy", busy, m_busy);
        chk("owner", owner, m_owner);
        chk("beats", beats, m_beats);
        // drive
        for (int c = 0; c < N; c++) begin
            if (!act[c] && $urandom_range(0, 99) < start_pct)
                load(c, $urandom_range(1, 5));
            ch_valid[c] = act[c] && (!bub || $urandom_range(0, 9) != 0);
            ch_last[c]  = (rem[c] == 1);
            ch_req[c*RW +: RW] = cur_req[c];
            ch_rsp_ready[c] = ($urandom_range(0, 99) < crr_pct);
        end
        dp_req_ready = ($urandom_range(0, 99) < rdy_pct);
        dp_rsp_valid = (rspq.size() != 0) && !rsp_hold
                       && ($urandom_range(0, 99) < rsp_pct);
        dp_rsp = (rspq.size() != 0) ? rspq[0] : SW'($urandom);
        #1;
        // routing and gating
        ev = !rst && m_busy && ch_valid[m_owner] && !m_done && (m_outst < MO);
        chk("dp_req_valid", dp_req_valid, ev);
        er = '0;
        if (ev && dp_req_ready) er[m_owner] = 1'b1;
        chk("ch_ready", ch_ready, er);
        if (ev) chk("dp_req", dp_req, cur_req[m_owner]);
        eo = !rst && m_busy && (m_outst > 0);
        chk("dp_rsp_ready", dp_rsp_ready, eo && ch_rsp_ready[m_owner]);
        ecv = '0;
        if (eo && dp_rsp_valid) ecv[m_owner] = 1'b1;
        chk("ch_rsp_valid", ch_rsp_valid, ecv);
        if (dp_rsp_valid) chk("ch_rsp", ch_rsp, dp_rsp);
        req_hs = dp_req_valid && dp_req_ready;
        rsp_hs = dp_rsp_valid && dp_rsp_ready;
        // model update for the coming edge
        if (rst) begin
            m_busy = 0; m_done = 0; m_owner = 0; m_rr = 0;
            m_outst = 0; m_beats = 0;
            rspq.delete();
            for (int c = 0; c < N; c++) begin
                sent[c] = 0;
                recvd[c] = 0;
            end
        end else if (!m_busy) begin
            found = 0;
            for (int k = 0; k < N; k++) begin
                int c = (m_rr + k) % N;
                if (!found && ch_valid[c]) begin
                    found = 1;
                    m_owner = c;
                end
            end
            if (found) begin
                m_busy = 1;
                m_beats = 0;
                grants.push_back(m_owner);
            end
        end else begin
            lst = m_done;
            if (rsp_hs) begin
                m_outst--;
                recvd[m_owner]++;
                void'(rspq.pop_front());
            end
            if (req_hs) begin
                if (m_beats < (1 << CW) - 1) m_beats++;
                m_outst++;
                if (ch_last[m_owner]) m_done = 1;
                sent[m_owner]++;
                rspq.push_back(SW'($urandom));
                rem[m_owner]--;
                if (rem[m_owner] == 0) act[m_owner] = 1'b0;
                cur_req[m_owner] = $urandom;
            end
            if (lst && m_outst == 0) begin
                m_busy = 0;
                m_done = 0;
                m_rr = (m_owner + 1) % N;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ch_req = '0; ch_last = '0; ch_valid = '0; ch_rsp_ready = '0;
        dp_req_ready = 0; dp_rsp = '0; dp_rsp_valid = 0;
        act = '0;
        for (int c = 0; c < N; c++) begin
            rem[c] = 0; cur_req[c] = '0; sent[c] = 0; recvd[c] = 0;
        end
        start_pct = 0; rdy_pct = 100; rsp_pct = 100; crr_pct = 100;
        bub = 0; rsp_hold = 0;
        m_busy = 0; m_done = 0; m_owner = 0; m_rr = 0;
        m_outst = 0; m_beats = 0;
        @(posedge clk);
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;

        // single channel, three beats
        load(1, 3);
        for (int i = 0; i < 40 && !all_idle(); i++) cycle();
        chk("single_done", all_idle(), 1);
        chk("single_beats", beats, 3);
        chk("single_idle", busy, 0);

        // contention at reset exit
        load(0, 2);
        load(2, 2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        grants.delete();
        for (int i = 0; i < 40 && !all_idle(); i++) cycle();
        chk("cont_done", all_idle(), 1);
        chk("cont_n", grants.size(), 2);
        if (grants.size() >= 2) begin
            chk("cont_first", grants[0], 0);
            chk("cont_second", grants[1], 2);
        end

        // outstanding limit with responses held back
        rsp_hold = 1;
        load(3, 4);
        for (int i = 0; i < 7; i++) cycle();
        chk("bp_beats", beats, 2);
        chk("bp_reqv", dp_req_valid, 0);
        rsp_hold = 0;
        for (int i = 0; i < 40 && !all_idle(); i++) cycle();
        chk("bp_done", all_idle(), 1);
        chk("bp_total", beats, 4);

        // response stall after the last beat
        load(0, 2);
        for (int i = 0; i < 20 && !m_done; i++) cycle();
        chk("stall_last", m_done, 1);
        crr_pct = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("stall_busy", busy, 1);
        chk("stall_rdy", dp_rsp_ready, 0);
        crr_pct = 100;
        for (int i = 0; i < 20 && !all_idle(); i++) cycle();
        chk("stall_done", all_idle(), 1);
        chk("stall_idle", busy, 0);

        // round-robin wrap from pointer 3
        load(2, 1);
        for (int i = 0; i < 20 && !all_idle(); i++) cycle();
        grants.delete();
        load(1, 1);
        load(3, 1);
        for (int i = 0; i < 40 && !all_idle(); i++) cycle();
        chk("wrap_n", grants.size(), 2);
        if (grants.size() >= 2) begin
            chk("wrap_first", grants[0], 3);
            chk("wrap_second", grants[1], 1);
        end

        // reset in the middle of a grant
        rsp_hold = 1;
        load(3, 3);
        for (int i = 0; i < 20 && m_outst != 1; i++) cycle();
        chk("mid_outst", m_outst, 1);
        chk("mid_owner", owner, 3);
        rst = 1'b1;
        act = '0;
        cycle();
        rst = 1'b0;
        rsp_hold = 0;
        chk("mid_busy", busy, 0);
        chk("mid_owner0", owner, 0);
        chk("mid_beats0", beats, 0);
        cycle();
        grants.delete();
        load(3, 1);
        load(1, 1);
        for (int i = 0; i < 40 && !all_idle(); i++) cycle();
        chk("mid_rr_n", grants.size(), 2);
        if (grants.size() >= 1) chk("mid_rr_first", grants[0], 1);

        // random traffic
        start_pct = 10; rdy_pct = 70; rsp_pct = 60; crr_pct = 70; bub = 1;
        for (int i = 0; i < 1500; i++) cycle();
        start_pct = 0;
        for (int i = 0; i < 600 && !all_idle(); i++) cycle();
        chk("drain_done", all_idle(), 1);
        for (int c = 0; c < N; c++) chk("rsp_count", recvd[c], sent[c]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
